pipe_perf_counter: RTL and testbench

PIPE_PERF_COUNTER -- requirements
Module: pipe_perf_counter

---
 rtl/pipe_perf_counter.sv | 108 ++++++++++
 tb/tb_pipe_perf_counter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_perf_counter.sv
// Pipeline performance counters: cycles, stalls, flushes and retirements counted
// while the CPU runs, with saturating counters, a snapshot bank and a run-length limit.
module pipe_perf_counter #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             hazard_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             snap_req_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_stall_o,
  output logic [CNT_W-1:0] snap_flush_o,
  output logic [CNT_W-1:0] snap_retire_o,
  output logic             snap_valid_o,
  output logic             running_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] snap_cycle_q, snap_stall_q, snap_flush_q, snap_retire_q;
  logic             snap_valid_q;
  logic             count_en;
  logic             hit_max;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  // The edge that takes IDLE into RUN is already a counted edge, so a resumed
  // run continues from the held value on the first edge with start_i high.
  assign count_en = start_i && (state_q != S_DONE);
  assign hit_max  = count_en && (MAX_CYCLES != 0) && (cycle_q == LAST_CYCLE);

  always_comb begin
    cycle_d  = sat_inc(cycle_q, count_en);
    stall_d  = sat_inc(stall_q, count_en && hazard_i && !jump_i && !branch_i);
    flush_d  = sat_inc(flush_q, count_en && flush_i);
    retire_d = sat_inc(retire_q, count_en && retire_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q       <= S_IDLE;
      cycle_q       <= '0;
      stall_q       <= '0;
      flush_q       <= '0;
      retire_q      <= '0;
      snap_cycle_q  <= '0;
      snap_stall_q  <= '0;
      snap_flush_q  <= '0;
      snap_retire_q <= '0;
      snap_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_q <= hit_max ? S_DONE : S_RUN;
        S_RUN:   if (!start_i) state_q <= S_IDLE;
                 else if (hit_max) state_q <= S_DONE;
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
      cycle_q      <= cycle_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      retire_q     <= retire_d;
      snap_valid_q <= snap_req_i;
      // Snapshot captures the pre-increment values of this edge.
      if (snap_req_i) begin
        snap_cycle_q  <= cycle_q;
        snap_stall_q  <= stall_q;
        snap_flush_q  <= flush_q;
        snap_retire_q <= retire_q;
      end
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign stall_cnt_o   = stall_q;
  assign flush_cnt_o   = flush_q;
  assign retire_cnt_o  = retire_q;
  assign snap_cycle_o  = snap_cycle_q;
  assign snap_stall_o  = snap_stall_q;
  assign snap_flush_o  = snap_flush_q;
  assign snap_retire_o = snap_retire_q;
  assign snap_valid_o  = snap_valid_q;
  assign running_o     = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_pipe_perf_counter.sv
// Scoreboard bench for pipe_perf_counter: a driver queues expected values per cycle,
// a negedge monitor pops and compares them, and pops snapshot records on snap_valid_o.
module tb_pipe_perf_counter;

  localparam int SEL_CYC = 0, SEL_STL = 1, SEL_FLS = 2, SEL_RET = 3, SEL_RUN = 4,
                 SEL_DONE = 5, SEL_SV = 6, SEL_SCYC = 7, SEL_SSTL = 8,
                 SEL_C2CYC = 9, SEL_C2STL = 10, SEL_C2DONE = 11, SEL_C2RUN = 12;

  typedef struct {
    string       name;
    int          at;
    int          sel;
    logic [31:0] v;
  } chk_t;

  typedef struct {
    logic [31:0] c, s, f, r;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, start2 = 1'b0, clear = 1'b0;
  logic hazard = 1'b0, jump = 1'b0, branch = 1'b0, flush = 1'b0, retire = 1'b0, snap_req = 1'b0;

  logic [31:0] cyc_o, stl_o, fls_o, ret_o, scyc_o, sstl_o, sfls_o, sret_o;
  logic        sv_o, run_o, done_o;
  logic [3:0]  c2_cyc, c2_stl, c2_fls, c2_ret, c2_scyc, c2_sstl, c2_sfls, c2_sret;
  logic        c2_sv, c2_run, c2_done;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  chk_t chk_q[$];
  snap_t snap_q[$];
  chk_t e;
  snap_t s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_perf_counter dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .hazard_i(hazard), .jump_i(jump), .branch_i(branch), .flush_i(flush),
    .retire_i(retire), .snap_req_i(snap_req),
    .cycle_cnt_o(cyc_o), .stall_cnt_o(stl_o), .flush_cnt_o(fls_o), .retire_cnt_o(ret_o),
    .snap_cycle_o(scyc_o), .snap_stall_o(sstl_o), .snap_flush_o(sfls_o), .snap_retire_o(sret_o),
    .snap_valid_o(sv_o), .running_o(run_o), .done_o(done_o)
  );

  pipe_perf_counter #(.CNT_W(4), .MAX_CYCLES(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .clear_i(clear),
    .hazard_i(hazard), .jump_i(jump), .branch_i(branch), .flush_i(flush),
    .retire_i(retire), .snap_req_i(snap_req),
    .cycle_cnt_o(c2_cyc), .stall_cnt_o(c2_stl), .flush_cnt_o(c2_fls), .retire_cnt_o(c2_ret),
    .snap_cycle_o(c2_scyc), .snap_stall_o(c2_sstl), .snap_flush_o(c2_sfls), .snap_retire_o(c2_sret),
    .snap_valid_o(c2_sv), .running_o(c2_run), .done_o(c2_done)
  );

  function automatic logic [31:0] got(int sel);
    case (sel)
      SEL_CYC:    return cyc_o;
      SEL_STL:    return stl_o;
      SEL_FLS:    return fls_o;
      SEL_RET:    return ret_o;
      SEL_RUN:    return {31'd0, run_o};
      SEL_DONE:   return {31'd0, done_o};
      SEL_SV:     return {31'd0, sv_o};
      SEL_SCYC:   return scyc_o;
      SEL_SSTL:   return sstl_o;
      SEL_C2CYC:  return {28'd0, c2_cyc};
      SEL_C2STL:  return {28'd0, c2_stl};
      SEL_C2DONE: return {31'd0, c2_done};
      SEL_C2RUN:  return {31'd0, c2_run};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares queued per-cycle expectations and snapshot records.
  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
      e = chk_q.pop_front();
      checks++;
      if (e.at != cyc || got(e.sel) !== e.v) begin
        failures++;
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, got(e.sel), e.v);
      end
    end
    if (sv_o) begin
      checks++;
      if (snap_q.size() == 0) begin
        failures++;
        $display("FAIL snap_unexpected (cycle %0d): snap_valid_o=1, expected no snapshot", cyc);
      end else begin
        s = snap_q.pop_front();
        if ({scyc_o, sstl_o, sfls_o, sret_o} !== {s.c, s.s, s.f, s.r}) begin
          failures++;
          $display("FAIL snap_regs (cycle %0d): got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                   cyc, scyc_o, sstl_o, sfls_o, sret_o, s.c, s.s, s.f, s.r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int sel, logic [31:0] v);
    chk_t c;
    c.name = nm; c.at = cyc; c.sel = sel; c.v = v;
    chk_q.push_back(c);
  endtask

  task automatic snap_exp(logic [31:0] c, logic [31:0] st, logic [31:0] f, logic [31:0] r);
    snap_t x;
    x.c = c; x.s = st; x.f = f; x.r = r;
    snap_q.push_back(x);
  endtask

  task automatic ev(logic h, logic j, logic b, logic f, logic r, logic sq);
    hazard = h; jump = j; branch = b; flush = f; retire = r; snap_req = sq;
  endtask

  task automatic zero_checks(string nm);
    chk({nm, "_cyc"}, SEL_CYC, 0);
    chk({nm, "_stall"}, SEL_STL, 0);
    chk({nm, "_run"}, SEL_RUN, 0);
    chk({nm, "_done"}, SEL_DONE, 0);
    chk({nm, "_sv"}, SEL_SV, 0);
    chk({nm, "_scyc"}, SEL_SCYC, 0);
  endtask

  task automatic run_to_done(string nm);
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk({nm, "_cyc"}, SEL_CYC, k);
      if (k == 29) chk({nm, "_notdone29"}, SEL_DONE, 0);
    end
    chk({nm, "_done"}, SEL_DONE, 1);
    chk({nm, "_run_off"}, SEL_RUN, 0);
  endtask

  initial begin
    // Reset state
    step(); step();
    zero_checks("reset");
    rst = 1'b0;

    // Run to the cycle limit with no events, then events in DONE must not count
    run_to_done("p1");
    chk("p1_c2_idle", SEL_C2CYC, 0);
    for (int k = 0; k < 5; k++) begin
      ev(1, 0, 0, 1, 1, (k == 4));
      step();
      chk("p1_frozen_cyc", SEL_CYC, 30);
      chk("p1_frozen_stall", SEL_STL, 0);
    end
    snap_exp(30, 0, 0, 0);
    chk("p1_done_snap_sv", SEL_SV, 1);

    // Clear in DONE with a snapshot request
    ev(0, 0, 0, 0, 0, 1); clear = 1'b1; start = 1'b1;
    step();
    zero_checks("clr");
    clear = 1'b0;

    // Stall/flush qualification
    ev(1, 0, 0, 0, 0, 0); step();
    ev(1, 0, 1, 0, 0, 0); step();
    ev(1, 0, 0, 1, 0, 0); step();
    ev(1, 0, 0, 1, 0, 0); step();
    chk("p2_cyc4", SEL_CYC, 4);
    chk("p2_stall", SEL_STL, 3);
    chk("p2_flush", SEL_FLS, 2);
    chk("p2_run", SEL_RUN, 1);
    ev(1, 1, 0, 0, 0, 0); step();
    chk("p2_jump_nostall", SEL_STL, 3);
    ev(0, 0, 0, 0, 1, 0); step();
    ev(0, 0, 0, 0, 0, 0); step();
    chk("p2_cyc7", SEL_CYC, 7);
    chk("p2_ret1", SEL_RET, 1);

    // Snapshot at cycle 7 with a retire on the same edge, then back-to-back requests
    ev(0, 0, 0, 0, 1, 1); step();
    snap_exp(7, 3, 2, 1);
    chk("snap_cyc_after", SEL_CYC, 8);
    chk("snap_ret_after", SEL_RET, 2);
    chk("snap_sv1", SEL_SV, 1);
    ev(0, 0, 0, 0, 0, 1); step();
    snap_exp(8, 3, 2, 2);
    chk("snap_b2b_sv", SEL_SV, 1);
    ev(0, 0, 0, 0, 0, 1); step();
    snap_exp(9, 3, 2, 2);
    chk("snap_b2b_cyc", SEL_CYC, 10);

    // Pause at cycle 10 for three edges, events must not count
    ev(1, 0, 0, 1, 1, 0); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pause_cyc", SEL_CYC, 10);
      chk("pause_run", SEL_RUN, 0);
    end
    chk("pause_sv_off", SEL_SV, 0);
    chk("pause_stall", SEL_STL, 3);
    ev(0, 0, 0, 0, 0, 0); start = 1'b1;
    step();
    chk("resume_cyc", SEL_CYC, 11);
    chk("resume_run", SEL_RUN, 1);

    // Reset mid-run beats clear, start and snapshot request
    rst = 1'b1; clear = 1'b1; ev(1, 0, 0, 1, 1, 1);
    step();
    zero_checks("rst_mid");
    rst = 1'b0; clear = 1'b0; ev(0, 0, 0, 0, 0, 0);

    // Reset together with clear in DONE
    run_to_done("p3");
    rst = 1'b1; clear = 1'b1; snap_req = 1'b1;
    step();
    zero_checks("rst_clr_done");
    rst = 1'b0; clear = 1'b0; snap_req = 1'b0; start = 1'b0;

    // Narrow unlimited instance saturates; main instance holds in IDLE
    ev(1, 0, 0, 1, 1, 0); start2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15) chk("sat_cyc15", SEL_C2CYC, 15);
    end
    chk("sat_cyc20", SEL_C2CYC, 15);
    chk("sat_stall", SEL_C2STL, 15);
    chk("sat_notdone", SEL_C2DONE, 0);
    chk("sat_run", SEL_C2RUN, 1);
    chk("idle_hold_cyc", SEL_CYC, 0);
    chk("idle_hold_flush", SEL_FLS, 0);
    ev(0, 0, 0, 0, 0, 0); start2 = 1'b0;

    repeat (3) step();
    checks++;
    if (snap_q.size() != 0 || chk_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d snapshots and %0d checks left, expected 0 and 0",
               snap_q.size(), chk_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
